// File: rtl/bram_read_stream.sv
// bram_read_stream: valid/ready front end for one port of a 2-cycle-latency BRAM.
// In-flight reads hold credits so the response FIFO can never overflow.
module bram_read_stream #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 10,
  parameter int TAG_WIDTH  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_is_write,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic [DATA_WIDTH-1:0]         req_wdata,
  input  logic [TAG_WIDTH-1:0]          req_tag,
  output logic [ADDR_WIDTH-1:0]         bram_addr,
  output logic [DATA_WIDTH-1:0]         bram_din,
  output logic                          bram_we,
  output logic                          bram_en,
  output logic                          bram_regce,
  output logic                          bram_reset,
  input  logic [DATA_WIDTH-1:0]         bram_dout,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic [TAG_WIDTH-1:0]          resp_tag,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = PW + 1;
  localparam logic [OW-1:0] DEPTH = OW'(FIFO_DEPTH);
  logic                           s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic [TAG_WIDTH-1:0]           s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
  logic [PW-1:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]                  count_q, count_d, occ_q, occ_d;
  logic [DATA_WIDTH+TAG_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH+TAG_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic                           rd_acc, push, pop;

  // credit check uses registered occupancy only, so no path from resp_ready
  assign req_ready  = reset && (occ_q < DEPTH);
  assign bram_en    = req_valid && req_ready;
  assign bram_we    = bram_en && req_is_write;
  assign bram_addr  = req_addr;
  assign bram_din   = req_wdata;
  assign bram_regce = reset;
  assign bram_reset = ~reset;
  assign rd_acc     = bram_en && !req_is_write;
  assign push       = s2_v_q;
  assign resp_valid = count_q != '0;
  assign pop        = resp_valid && resp_ready;
  assign {resp_data, resp_tag} = mem_q[rd_ptr_q];
  assign occupancy  = occ_q;

  always_comb begin
    s1_v_d   = rd_acc;
    s1_tag_d = req_tag;
    s2_v_d   = s1_v_q;
    s2_tag_d = s1_tag_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + OW'(push) - OW'(pop);
    occ_d    = occ_q + OW'(rd_acc) - OW'(pop);
    mem_d    = mem_q;
    if (push) mem_d[wr_ptr_q] = {bram_dout, s2_tag_q};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_v_q   <= 1'b0;
      s2_v_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      occ_q    <= '0;
    end else begin
      s1_v_q   <= s1_v_d;
      s2_v_q   <= s2_v_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clock) begin
    s1_tag_q <= s1_tag_d;
    s2_tag_q <= s2_tag_d;
    mem_q    <= mem_d;
  end

  always_ff @(posedge clock) begin
    if (reset && push) assert (count_q != DEPTH || pop) else $error("response fifo overflow");
  end
endmodule

// File: tb/tb_bram_read_stream.sv
// tb_bram_read_stream: directed bench with a read-first BRAM model and an in-order response scoreboard.
module tb_bram_read_stream;
  localparam int DW = 18, AW = 10, TW = 4, FD = 4;
  logic clock = 0, reset = 0;
  logic req_valid = 0, req_is_write = 0, req_ready;
  logic [AW-1:0] req_addr = '0, bram_addr;
  logic [DW-1:0] req_wdata = '0, bram_din, bram_dout, resp_data;
  logic [TW-1:0] req_tag = '0, resp_tag;
  logic bram_we, bram_en, bram_regce, bram_reset, resp_valid, resp_ready;
  logic rr_fixed = 0, tog = 0, toggle_en = 0;
  logic [$clog2(FD):0] occupancy;
  logic [DW-1:0] bram_mem [1<<AW];
  logic [DW-1:0] ref_mem [1<<AW];
  logic [DW-1:0] bram_lat;
  logic [TW+DW-1:0] sb [$];
  logic [TW+DW-1:0] exp_e;
  int checks = 0, errors = 0, resp_cnt = 0, max_occ = 0;
  int base, stall, w;

  assign resp_ready = toggle_en ? tog : rr_fixed;

  bram_read_stream #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .FIFO_DEPTH(FD)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_write(req_is_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we), .bram_en(bram_en),
    .bram_regce(bram_regce), .bram_reset(bram_reset), .bram_dout(bram_dout),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_tag(resp_tag),
    .occupancy(occupancy));

  always #5 clock = ~clock;
  always @(posedge clock) tog <= ~tog;

  // read-first port with latch stage plus output register
  always @(posedge clock) begin
    if (bram_en) begin
      bram_lat <= bram_mem[bram_addr];
      if (bram_we) bram_mem[bram_addr] <= bram_din;
    end
    if (bram_reset) bram_dout <= '0;
    else if (bram_regce) bram_dout <= bram_lat;
  end

  always @(negedge clock) begin
    if (!reset) sb.delete();
    else begin
      checks++;
      assert (occupancy === 3'(sb.size())) else begin
        errors++; $error("FAIL occupancy got %0d exp %0d", occupancy, sb.size());
      end
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
      if (resp_valid && resp_ready) begin
        resp_cnt++;
        checks++;
        assert (sb.size() != 0) else begin
          errors++; $error("FAIL unexpected_resp got tag %0h data %0h exp none", resp_tag, resp_data);
        end
        if (sb.size() != 0) begin
          exp_e = sb.pop_front();
          checks++;
          assert ({resp_tag, resp_data} === exp_e) else begin
            errors++; $error("FAIL resp got tag %0h data %0h exp tag %0h data %0h",
                             resp_tag, resp_data, exp_e[TW+DW-1:DW], exp_e[DW-1:0]);
          end
        end
      end
      if (req_valid && req_ready) begin
        if (req_is_write) ref_mem[req_addr] = req_wdata;
        else sb.push_back({req_tag, ref_mem[req_addr]});
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++; $error("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [TW-1:0] t, output int waited);
    req_valid = 1; req_is_write = wr; req_addr = a; req_wdata = d; req_tag = t; waited = 0;
    @(negedge clock);
    while (!req_ready && waited < 100) begin waited++; @(negedge clock); end
    checks++;
    assert (req_ready) else begin
      errors++; $error("FAIL send_timeout got ready %0b exp 1 addr %0h", req_ready, a);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 0; req_valid = 1; rr_fixed = 1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_bram_en", 32'(bram_en), 0);
    chk("rst_bram_we", 32'(bram_we), 0);
    chk("rst_bram_reset", 32'(bram_reset), 1);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_occupancy", 32'(occupancy), 0);
    @(posedge clock); #1;
    reset = 1; req_valid = 0;
    @(negedge clock);
    chk("post_rst_ready", 32'(req_ready), 1);
    chk("post_rst_regce", 32'(bram_regce), 1);
    tick(1);

    send(1, AW'(5), DW'(18'h2A5A5), TW'(0), w);
    send(0, AW'(5), DW'(0), TW'(3), w);
    req_valid = 0;
    @(negedge clock); chk("lat_t1", 32'(resp_valid), 0);
    @(negedge clock); chk("lat_t2", 32'(resp_valid), 0);
    @(negedge clock); chk("lat_t3", 32'(resp_valid), 1);
    chk("wr_rd_data", 32'(resp_data), 32'h2A5A5);
    chk("wr_rd_tag", 32'(resp_tag), 3);
    tick(2);

    for (int i = 0; i < 16; i++) send(1, AW'(i), DW'(i), TW'(0), w);
    req_valid = 0;
    tick(1);

    max_occ = 0; base = resp_cnt; stall = 0;
    for (int i = 0; i < 16; i++) begin send(0, AW'(i), DW'(0), TW'(i), w); stall += w; end
    req_valid = 0;
    tick(4);
    chk("stream_stall", 32'(stall), 0);
    chk("stream_count", 32'(resp_cnt - base), 16);
    chk("stream_max_occ_le3", 32'(max_occ <= 3), 1);

    rr_fixed = 0; base = resp_cnt; stall = 0;
    for (int i = 0; i < 4; i++) begin send(0, AW'(i), DW'(0), TW'(i), w); stall += w; end
    chk("bp_first4_stall", 32'(stall), 0);
    req_is_write = 0; req_addr = AW'(4); req_tag = TW'(4); req_valid = 1;
    tick(3);
    @(negedge clock);
    chk("bp_ready", 32'(req_ready), 0);
    chk("bp_occupancy", 32'(occupancy), 4);
    chk("bp_no_resp", 32'(resp_cnt - base), 0);
    @(posedge clock); #1;
    rr_fixed = 1;
    for (int i = 4; i < 8; i++) send(0, AW'(i), DW'(0), TW'(i), w);
    req_valid = 0;
    tick(8);
    chk("bp_count", 32'(resp_cnt - base), 8);
    chk("bp_sb_empty", 32'(sb.size()), 0);

    base = resp_cnt; max_occ = 0; toggle_en = 1;
    for (int i = 0; i < 64; i++) send(0, AW'((i * 7) % 16), DW'(0), TW'(i % 16), w);
    req_valid = 0;
    tick(20);
    toggle_en = 0; rr_fixed = 0;
    tick(1);
    chk("full_count", 32'(resp_cnt - base), 64);
    chk("full_sb_empty", 32'(sb.size()), 0);
    chk("full_reached", 32'(max_occ), 4);

    base = resp_cnt;
    for (int i = 0; i < 4; i++) send(0, AW'(i), DW'(0), TW'(8 + i), w);
    req_valid = 0; reset = 0;
    @(negedge clock);
    chk("pre_rst_occ", 32'(occupancy), 4);
    chk("pre_rst_valid", 32'(resp_valid), 1);
    @(posedge clock); #1;
    reset = 1;
    @(negedge clock);
    chk("mid_rst_valid", 32'(resp_valid), 0);
    chk("mid_rst_occ", 32'(occupancy), 0);
    @(posedge clock); #1;
    rr_fixed = 1;
    tick(5);
    chk("mid_rst_no_resp", 32'(resp_cnt - base), 0);
    send(0, AW'(9), DW'(0), TW'(7), w);
    req_valid = 0;
    tick(6);
    chk("mid_rst_one_resp", 32'(resp_cnt - base), 1);
    chk("mid_rst_sb_empty", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bram_read_stream.md
Name: bram_read_stream

Overview:
- Valid/ready front end for one port of a true dual-port, read-first, single-clock BRAM with registered output (2-cycle read latency).
- Accepts read and write requests from an MSHR or cache controller.
- Drives the BRAM port signals and tracks reads in flight.
- Collects read data into a credit-protected response FIFO, so read data is never lost under downstream backpressure.

Parameters:
- DATA_WIDTH, 18, BRAM word width
- ADDR_WIDTH, 10, BRAM address width
- TAG_WIDTH, 4, opaque request tag returned with read data
- FIFO_DEPTH, 4, response FIFO entries; must be ≥4 to sustain 1 read/cycle; power of two

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  request offered
- req_ready  out  1  request accepted when req_valid && req_ready
- req_is_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  address
- req_wdata  in  DATA_WIDTH  write data
- req_tag  in  TAG_WIDTH  read tag
- bram_addr  out  ADDR_WIDTH  to BRAM port address
- bram_din  out  DATA_WIDTH  to BRAM port data in
- bram_we  out  1  BRAM write enable
- bram_en  out  1  BRAM port enable
- bram_regce  out  1  BRAM output register enable
- bram_reset  out  1  BRAM output-register reset, active-high
- bram_dout  in  DATA_WIDTH  BRAM registered output
- resp_valid  out  1  read response available
- resp_ready  in  1  consumer accepts response
- resp_data  out  DATA_WIDTH  read data
- resp_tag  out  TAG_WIDTH  tag of that read
- occupancy  out  clog2(FIFO_DEPTH)+1  reads in flight + FIFO entries

Behaviour:
- **Reset (reset==0 at posedge):**
  - Clears pipeline valid bits, FIFO pointers and count.
  - Outputs during and after reset: req_ready=0 while reset low, resp_valid=0, occupancy=0, bram_en=0, bram_we=0.
  - bram_reset = ~reset (combinational).
  - Reset mid-operation discards all in-flight reads and FIFO contents; no response is ever produced for them.
- **BRAM port drive (combinational from the accepted request):**
  - bram_en = req_valid && req_ready.
  - bram_we = bram_en && req_is_write.
  - bram_addr = req_addr; bram_din = req_wdata.
  - bram_regce = 1 whenever reset is high.
- **Credit rule:**
  - req_ready = reset && (occupancy < FIFO_DEPTH).
  - Computed from registered state only; no combinational path from resp_ready or from the request fields.
  - Writes are gated by the same rule but consume no credit.
- **Read pipeline:**
  - Two-stage shift register: s1 {valid, tag}, s2 {valid, tag}.
  - Accepted read in cycle T sets s1.valid at T+1 and s2.valid at T+2.
  - In cycle T+2, bram_dout holds that read's data; {bram_dout, s2.tag} is pushed into the FIFO at the end of T+2.
  - resp_valid rises at T+3 at the earliest. Load-to-response latency is exactly 3 cycles when the FIFO is empty.
- **Writes:**
  - Issued to the BRAM in the acceptance cycle; do not enter the pipeline; produce no response.
  - Read-first semantics on the same port keep ordering: a read accepted after a write to the same address returns the new data.
- **Occupancy:**
  - occupancy = s1.valid + s2.valid + fifo_count, registered.
  - Next value = current + read_accepted − fifo_pop.
  - The credit rule guarantees the FIFO is never pushed when full. An overflow push is an assertion failure in simulation.
- **Response FIFO:**
  - First-in first-out; resp_data/resp_tag are the head entry.
  - Pop when resp_valid && resp_ready.
  - Push and pop in the same cycle are legal at any count, including full and empty; empty with push gives resp_valid the next cycle (no bypass).
  - Pointers wrap modulo FIFO_DEPTH.
- **Throughput:** with resp_ready held high and FIFO_DEPTH ≥ 4, one read is accepted per cycle indefinitely.

Test Plan:
- **Reset values:** hold reset=0 for 3 cycles with req_valid=1 → req_ready=0, bram_en=0, bram_reset=1, resp_valid=0, occupancy=0.
- **Write then read:** write addr 0x005 data 0x2A5A5, then read addr 0x005 tag 3 on the next cycle → resp_valid exactly 3 cycles after read acceptance, resp_data=0x2A5A5, resp_tag=3.
- **Streaming:** with resp_ready=1, issue 16 back-to-back reads of addrs 0..15 (preloaded data=addr) with tags 0..15 → req_ready stays 1; responses arrive in order with data=tag=0..15, one per cycle, occupancy stays ≤3.
- **Backpressure:** hold resp_ready=0, offer 8 reads → exactly 4 accepted, then req_ready=0, occupancy=4, no data lost. Release resp_ready → 4 correct responses in order, then the remaining 4 are accepted and returned correctly.
- **Simultaneous push/pop at full:** FIFO full, resp_ready toggling every cycle with continuous reads → no overflow assertion, no duplicate or missing tags across 64 reads.
- **Reset mid-operation:** with 2 reads in flight and 2 in the FIFO, pulse reset low for 1 cycle → resp_valid=0 and occupancy=0 after reset; the next read returns only its own tag.
